fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
- Parametrised successor to the 2:1 operand-forwarding mux.
- Tracks up to DEPTH in-flight register writes in a shift-register scoreboard.
- Selects, per source operand, the youngest ready producer value over the register-file value, and raises a stall when the youngest producer is a load whose data has not returned.
- Sits between decode/regfile read and the ALU source muxes.

Parameters:
- XLEN, 32, datapath width.
- NUM_SRC, 2, number of source operands resolved in parallel.
- DEPTH, 2, number of in-flight producer entries tracked (≥1).
- RAW, 5, register address width.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- advance  input  1  pipeline advances this cycle
- issue_valid  input  1  instruction in issue stage is valid
- issue_we  input  1  issuing instruction writes rd
- issue_is_load  input  1  issuing instruction is a load; result not yet known
- issue_rd  input  RAW  destination register
- issue_result  input  XLEN  ALU result of the issuing instruction; ignored for loads
- load_data_valid  input  1  load data returning this cycle
- load_data  input  XLEN  returning load data
- rs_addr  input  NUM_SRC*RAW  source addresses; operand i at slice i
- rs_rdata  input  NUM_SRC*XLEN  register-file read data
- opnd_out  output  NUM_SRC*XLEN  resolved operands
- fwd_hit  output  NUM_SRC  operand i taken from the scoreboard
- stall  output  1  hold the issue stage
- lost_load  output  1  sticky: a load retired without its data

Behaviour:
- **Clock and reset.** Single clock (clk). rst is synchronous and active-high.
  - rst clears every entry's valid and ready bits, entry data, and lost_load.
  - After reset: stall=0, fwd_hit=0, opnd_out=rs_rdata.
- **Entry fields.** valid, rd, is_load, ready, data. Entry 0 is the youngest.
- **Shift.** On advance, entry k moves to k+1 and entry DEPTH-1 retires.
  - If stall=0, entry0 loads the issue fields: valid=issue_valid&issue_we, ready=!issue_is_load, data=issue_result.
  - If stall=1, entry0 receives a bubble (valid=0). The issuing instruction is replayed next cycle.
- **Load fill.**
  - On load_data_valid, target the oldest entry (pre-shift index) with valid&is_load&!ready. Set its ready=1 and data=load_data.
  - If a shift occurs in the same cycle, the filled entry lands at its shifted position with the fill applied.
  - If no pending entry exists, ignore the fill.
- **Retire.** If the retiring entry is a valid load with ready=0 and no same-cycle fill targets it, set lost_load=1. It stays set until rst.
- **Operand resolution.** Combinational from registered state only. There is no same-cycle issue-to-issue bypass.
  - For operand i, scan entries 0..DEPTH-1 and take the first with valid && rd==rs_addr[i].
  - If that entry is ready: opnd_out[i]=data and fwd_hit[i]=1.
  - If it is not ready: opnd_out[i]=rs_rdata[i], fwd_hit[i]=0, and stall is asserted.
  - If no entry matches: pass rs_rdata[i] through.
  - Older matches are never used when a younger one exists, even if the younger one is not ready.
- **x0.** rs_addr==0 never matches. Entries with rd==0 are still written but never match.
- **Stall.** OR over operands of "youngest match not ready". It does not depend on advance.
- **Latency.** A producer is forwardable the cycle after it enters entry0. Load data is forwardable the cycle after load_data_valid.

Optional Feature:
- Macro: FWD_HAZARD_STATS_EN.
- **Defined:** adds outputs stall_cycles[31:0] and fwd_count[31:0].
  - stall_cycles increments each cycle with stall=1.
  - fwd_count increments by popcount(fwd_hit) each cycle while stall=0.
  - Both saturate at all-ones and clear on rst.
- **Undefined:** the ports and counters are absent, with no other behavioural change.

Decomposition:
- **Shared package fwd_pkg:**
  - typedef sb_entry_t {valid, rd, is_load, ready, data}
  - the function that resolves one operand over the entry array
  - localparam REG_ZERO=0
- **Sub-module fwd_operand_sel:** one instance per operand (generate loop). Takes the entry array, rs_addr and rs_rdata; produces operand, hit and pending.

Test Plan:
- **Reset.** rst=1 for 2 cycles with rs_rdata=0x11 → opnd_out=0x11, stall=0, fwd_hit=0, lost_load=0.
- **ALU forward.** Issue rd=5 with result 0xDEAD and advance; next cycle rs_addr[0]=5 → opnd_out[0]=0xDEAD, fwd_hit[0]=1. Advance DEPTH more times → fwd_hit=0 and regfile value used.
- **Youngest wins.** Issue rd=3 with 0x1, then rd=3 with 0x2 → operand=0x2. Bubble → still 0x2 until that entry retires; 0x1 is never seen while 0x2 is resident.
- **Load-use stall.** Issue a load to rd=7; next cycle rs_addr[1]=7 → stall=1 and entry0 becomes a bubble on advance. Assert load_data_valid with 0xBEEF → next cycle stall=0, opnd_out[1]=0xBEEF.
- **x0 and simultaneous events.** Issue rd=0 with 0x55 and read rs=0 → no hit. Load fill in the same cycle as a shift → filled data at the shifted index.
- **Lost load (DEPTH=2).** Load never filled, 2 advances → lost_load=1. It stays 1 until rst.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared types and operand-resolution function for the forwarding/hazard unit.
// The scoreboard entry widths are fixed here; the unit's XLEN/RAW must match them.
package fwd_pkg;

  localparam int unsigned SB_XLEN   = 32;
  localparam int unsigned SB_RAW    = 5;
  localparam int unsigned MAX_DEPTH = 8;

  localparam logic [SB_RAW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic               valid;
    logic [SB_RAW-1:0]  rd;
    logic               is_load;
    logic               ready;
    logic [SB_XLEN-1:0] data;
  } sb_entry_t;

  typedef struct packed {
    logic [SB_XLEN-1:0] operand;
    logic               hit;
    logic               pending;
  } resolve_t;

  // Youngest matching entry decides; an older ready match never overrides it.
  function automatic resolve_t resolve_operand(input sb_entry_t [MAX_DEPTH-1:0] ents,
                                               input logic [SB_RAW-1:0]         rs_addr,
                                               input logic [SB_XLEN-1:0]        rs_rdata);
    resolve_t r;
    logic     found;
    r.operand = rs_rdata;
    r.hit     = 1'b0;
    r.pending = 1'b0;
    found     = 1'b0;
    for (int k = 0; k < MAX_DEPTH; k++) begin
      if (!found && (rs_addr != REG_ZERO) && ents[k].valid && (ents[k].rd == rs_addr)) begin
        found = 1'b1;
        if (ents[k].ready) begin
          r.operand = ents[k].data;
          r.hit     = 1'b1;
        end else begin
          r.pending = 1'b1;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fwd_operand_sel.sv
// Resolves one source operand against the in-flight producer scoreboard.
module fwd_operand_sel
  import fwd_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  sb_entry_t [DEPTH-1:0] ents,
  input  logic [SB_RAW-1:0]     rs_addr,
  input  logic [SB_XLEN-1:0]    rs_rdata,
  output logic [SB_XLEN-1:0]    operand,
  output logic                  hit,
  output logic                  pending
);

  sb_entry_t [MAX_DEPTH-1:0] padded;
  resolve_t                  res;

  // Unused slots stay invalid so the fixed-size scan ignores them.
  always_comb begin
    padded            = '0;
    padded[DEPTH-1:0] = ents;
    res               = resolve_operand(padded, rs_addr, rs_rdata);
  end

  assign operand = res.operand;
  assign hit     = res.hit;
  assign pending = res.pending;

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use hazard detection over a shift-register scoreboard.
// Optional FWD_HAZARD_STATS_EN adds saturating stall_cycles / fwd_count counters.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int unsigned XLEN    = SB_XLEN,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned RAW     = SB_RAW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    advance,
  input  logic                    issue_valid,
  input  logic                    issue_we,
  input  logic                    issue_is_load,
  input  logic [RAW-1:0]          issue_rd,
  input  logic [XLEN-1:0]         issue_result,
  input  logic                    load_data_valid,
  input  logic [XLEN-1:0]         load_data,
  input  logic [NUM_SRC*RAW-1:0]  rs_addr,
  input  logic [NUM_SRC*XLEN-1:0] rs_rdata,
  output logic [NUM_SRC*XLEN-1:0] opnd_out,
  output logic [NUM_SRC-1:0]      fwd_hit,
  output logic                    stall,
`ifdef FWD_HAZARD_STATS_EN
  output logic [31:0]             stall_cycles,
  output logic [31:0]             fwd_count,
`endif
  output logic                    lost_load
);

  sb_entry_t [DEPTH-1:0] ents_q, ents_d, ents_fill;
  sb_entry_t             issue_ent;
  logic [DEPTH-1:0]      fill_sel;
  logic [NUM_SRC-1:0]    pending;
  logic                  lost_q, lost_d;
  logic                  retire_unfilled;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_sel
    fwd_operand_sel #(
      .DEPTH (DEPTH)
    ) u_sel (
      .ents     (ents_q),
      .rs_addr  (rs_addr[g*RAW +: RAW]),
      .rs_rdata (rs_rdata[g*XLEN +: XLEN]),
      .operand  (opnd_out[g*XLEN +: XLEN]),
      .hit      (fwd_hit[g]),
      .pending  (pending[g])
    );
  end

  assign stall = |pending;

  // Later iterations overwrite earlier ones, so the oldest pending load is selected.
  always_comb begin
    fill_sel = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (ents_q[k].valid && ents_q[k].is_load && !ents_q[k].ready) begin
        fill_sel    = '0;
        fill_sel[k] = 1'b1;
      end
    end
  end

  always_comb begin
    issue_ent.valid   = issue_valid & issue_we;
    issue_ent.rd      = issue_rd;
    issue_ent.is_load = issue_is_load;
    issue_ent.ready   = ~issue_is_load;
    issue_ent.data    = issue_is_load ? '0 : issue_result;
  end

  always_comb begin
    ents_fill = ents_q;
    for (int k = 0; k < DEPTH; k++) begin
      if (load_data_valid && fill_sel[k]) begin
        ents_fill[k].ready = 1'b1;
        ents_fill[k].data  = load_data;
      end
    end
    ents_d = ents_fill;
    if (advance) begin
      for (int k = 1; k < DEPTH; k++) begin
        ents_d[k] = ents_fill[k-1];
      end
      // A stalled issue slot is replayed, so only a bubble enters the scoreboard.
      ents_d[0] = stall ? '0 : issue_ent;
    end
  end

  always_comb begin
    retire_unfilled = advance && ents_q[DEPTH-1].valid && ents_q[DEPTH-1].is_load &&
                      !ents_q[DEPTH-1].ready && !(load_data_valid && fill_sel[DEPTH-1]);
    lost_d          = lost_q | retire_unfilled;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ents_q <= '0;
      lost_q <= 1'b0;
    end else begin
      ents_q <= ents_d;
      lost_q <= lost_d;
    end
  end

  assign lost_load = lost_q;

`ifdef FWD_HAZARD_STATS_EN
  logic [31:0] stall_cycles_q, fwd_count_q;
  logic [32:0] fwd_sum;

  always_comb begin
    fwd_sum = {1'b0, fwd_count_q} + 33'($countones(fwd_hit));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
      fwd_count_q    <= '0;
    end else begin
      if (stall && (stall_cycles_q != '1)) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
      if (!stall) begin
        fwd_count_q <= fwd_sum[32] ? '1 : fwd_sum[31:0];
      end
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign fwd_count    = fwd_count_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Table-driven self-checking bench for fwd_hazard_unit (DEPTH=2, NUM_SRC=2).
module tb_fwd_hazard_unit;

  localparam logic [31:0] R0 = 32'h11;
  localparam logic [31:0] R1 = 32'h22;

  logic        clk = 1'b0;
  logic        rst;
  logic        advance, issue_valid, issue_we, issue_is_load, load_data_valid;
  logic [4:0]  issue_rd;
  logic [31:0] issue_result, load_data;
  logic [9:0]  rs_addr;
  logic [63:0] rs_rdata;
  logic [63:0] opnd_out;
  logic [1:0]  fwd_hit;
  logic        stall, lost_load;

  int checks = 0;
  int errors = 0;

  fwd_hazard_unit #(
    .XLEN    (32),
    .NUM_SRC (2),
    .DEPTH   (2),
    .RAW     (5)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .advance         (advance),
    .issue_valid     (issue_valid),
    .issue_we        (issue_we),
    .issue_is_load   (issue_is_load),
    .issue_rd        (issue_rd),
    .issue_result    (issue_result),
    .load_data_valid (load_data_valid),
    .load_data       (load_data),
    .rs_addr         (rs_addr),
    .rs_rdata        (rs_rdata),
    .opnd_out        (opnd_out),
    .fwd_hit         (fwd_hit),
    .stall           (stall),
    .lost_load       (lost_load)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, adv, iv, we, ld;
    logic [4:0]  rd;
    logic [31:0] res;
    logic        ldv;
    logic [31:0] ldd;
    logic [4:0]  ra0, ra1;
    logic [31:0] e0, e1;
    logic [1:0]  ehit;
    logic        estall, elost;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  function automatic vec_t mk(logic r, logic adv, logic iv, logic we, logic ld, logic [4:0] rd,
                              logic [31:0] res, logic ldv, logic [31:0] ldd, logic [4:0] ra0,
                              logic [4:0] ra1, logic [31:0] e0, logic [31:0] e1,
                              logic [1:0] ehit, logic estall, logic elost);
    vec_t v;
    v.rst = r; v.adv = adv; v.iv = iv; v.we = we; v.ld = ld; v.rd = rd; v.res = res;
    v.ldv = ldv; v.ldd = ldd; v.ra0 = ra0; v.ra1 = ra1; v.e0 = e0; v.e1 = e1;
    v.ehit = ehit; v.estall = estall; v.elost = elost;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rst             = v.rst;
    advance         = v.adv;
    issue_valid     = v.iv;
    issue_we        = v.we;
    issue_is_load   = v.ld;
    issue_rd        = v.rd;
    issue_result    = v.res;
    load_data_valid = v.ldv;
    load_data       = v.ldd;
    rs_addr         = {v.ra1, v.ra0};
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got 0x%0h expected 0x%0h", nm, idx, act, exp);
    end
  endtask

  task automatic compare(input int idx);
    vec_t e;
    e = exp_q.pop_front();
    chk("opnd0", idx, opnd_out[31:0], e.e0);
    chk("opnd1", idx, opnd_out[63:32], e.e1);
    chk("fwd_hit", idx, {30'd0, fwd_hit}, {30'd0, e.ehit});
    chk("stall", idx, {31'd0, stall}, {31'd0, e.estall});
    chk("lost_load", idx, {31'd0, lost_load}, {31'd0, e.elost});
  endtask

  initial begin
    // rst adv iv we ld rd res ldv ldd ra0 ra1 | e0 e1 hit stall lost
    // ALU forward, then aged out after DEPTH advances
    tbl.push_back(mk(0,1,1,1,0, 5,32'hDEAD,0,0,         5, 0, R0,       R1,       0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,       0,0,         5, 5, 32'hDEAD, 32'hDEAD, 3,0,0));
    tbl.push_back(mk(0,1,0,0,0, 0,0,       0,0,         5, 0, 32'hDEAD, R1,       1,0,0));
    tbl.push_back(mk(0,1,0,0,0, 0,0,       0,0,         5, 0, 32'hDEAD, R1,       1,0,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,       0,0,         5, 0, R0,       R1,       0,0,0));
    // youngest wins
    tbl.push_back(mk(0,1,1,1,0, 3,32'h1,   0,0,         3, 0, R0,       R1,       0,0,0));
    tbl.push_back(mk(0,1,1,1,0, 3,32'h2,   0,0,         3, 0, 32'h1,    R1,       1,0,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,       0,0,         3, 3, 32'h2,    32'h2,    3,0,0));
    tbl.push_back(mk(0,1,0,0,0, 0,0,       0,0,         3, 0, 32'h2,    R1,       1,0,0));
    tbl.push_back(mk(0,1,0,0,0, 0,0,       0,0,         3, 0, 32'h2,    R1,       1,0,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,       0,0,         3, 0, R0,       R1,       0,0,0));
    // load-use stall, bubble insertion, fill, replay
    tbl.push_back(mk(0,1,1,1,1, 7,32'h999, 0,0,         0, 7, R0,       R1,       0,0,0));
    tbl.push_back(mk(0,1,1,1,0, 9,32'hAAAA,0,0,         0, 7, R0,       R1,       0,1,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,       1,32'hBEEF,  0, 7, R0,       R1,       0,1,0));
    tbl.push_back(mk(0,1,1,1,0, 9,32'hAAAA,0,0,         0, 7, R0,       32'hBEEF, 2,0,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,       0,0,         9, 7, 32'hAAAA, R1,       1,0,0));
    // x0 never matches
    tbl.push_back(mk(0,1,1,1,0, 0,32'h55,  0,0,         0, 9, R0,       32'hAAAA, 2,0,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,       0,0,         0, 0, R0,       R1,       0,0,0));
    // fill in the same cycle as a shift
    tbl.push_back(mk(0,1,1,1,1,12,0,       0,0,         9, 0, 32'hAAAA, R1,       1,0,0));
    tbl.push_back(mk(0,1,0,0,0, 0,0,       1,32'hCAFE,  12,0, R0,       R1,       0,1,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,       0,0,         12,0, 32'hCAFE, R1,       1,0,0));
    // fill with nothing pending is ignored
    tbl.push_back(mk(0,0,0,0,0, 0,0,       1,32'h1234,  12,0, 32'hCAFE, R1,       1,0,0));
    // younger pending load hides older ready producer
    tbl.push_back(mk(0,1,1,1,0,12,32'h77,  0,0,         12,0, 32'hCAFE, R1,       1,0,0));
    tbl.push_back(mk(0,1,1,1,1,12,0,       0,0,         12,0, 32'h77,   R1,       1,0,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,       0,0,         12,0, R0,       R1,       0,1,0));
    // load retires unfilled -> sticky lost_load until rst
    tbl.push_back(mk(0,1,0,0,0, 0,0,       0,0,         12,0, R0,       R1,       0,1,0));
    tbl.push_back(mk(0,1,0,0,0, 0,0,       0,0,         0, 0, R0,       R1,       0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,       0,0,         0, 0, R0,       R1,       0,0,1));
    tbl.push_back(mk(0,1,0,0,0, 0,0,       0,0,         0, 0, R0,       R1,       0,0,1));
    tbl.push_back(mk(1,0,0,0,0, 0,0,       0,0,         0, 0, R0,       R1,       0,0,1));
    tbl.push_back(mk(0,0,0,0,0, 0,0,       0,0,         0, 0, R0,       R1,       0,0,0));
    // fill arriving as the load retires is not lost
    tbl.push_back(mk(0,1,1,1,1, 4,0,       0,0,         0, 0, R0,       R1,       0,0,0));
    tbl.push_back(mk(0,1,0,0,0, 0,0,       0,0,         0, 0, R0,       R1,       0,0,0));
    tbl.push_back(mk(0,1,0,0,0, 0,0,       1,32'h4444,  0, 0, R0,       R1,       0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,       0,0,         0, 0, R0,       R1,       0,0,0));
    // two pending loads: fills go oldest first
    tbl.push_back(mk(0,1,1,1,1, 6,0,       0,0,         0, 0, R0,       R1,       0,0,0));
    tbl.push_back(mk(0,1,1,1,1, 8,0,       0,0,         0, 0, R0,       R1,       0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,       1,32'h6666,  6, 8, R0,       R1,       0,1,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,       0,0,         6, 8, 32'h6666, R1,       1,1,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,       1,32'h8888,  6, 8, 32'h6666, R1,       1,1,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,       0,0,         6, 8, 32'h6666, 32'h8888, 3,0,0));
    // issue without write enable leaves a non-matching entry
    tbl.push_back(mk(0,1,1,0,0, 6,32'h9,   0,0,         6, 8, 32'h6666, 32'h8888, 3,0,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,       0,0,         6, 8, R0,       32'h8888, 2,0,0));

    rs_rdata = {R1, R0};
    drive(mk(1,0,0,0,0,0,0,0,0,0,0,R0,R1,0,0,0));
    repeat (2) @(posedge clk);
    exp_q.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,R0,R1,0,0,0));
    @(negedge clk);
    compare(-1);

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk);
      #1;
      drive(tbl[i]);
      exp_q.push_back(tbl[i]);
      @(negedge clk);
      compare(i);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
